// File: rtl/spram_initiator_pkg.sv
// Shared definitions for the SPRAM initiator and its helpers.
//   ADDR_W / DATA_W : default byte-address and data widths of the SPRAM wrapper
//   SB              : byte strobes per data word
//   STRB_FULL       : strobe pattern of a whole-word store
//   state_t         : initiator FSM states
package spram_initiator_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int SB     = DATA_W / 8;

    localparam logic [SB-1:0] STRB_FULL = {SB{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,        // read pulse on the SPRAM (load or first half of RMW)
        ST_RD_WAIT,   // load waiting for rd_valid
        ST_WR,        // write pulse on the SPRAM
        ST_RMW_WAIT,  // partial store waiting for the old word
        ST_RESP       // single-cycle response
    } state_t;

endpackage

// File: rtl/spram_byte_merge.sv
// Combinational byte-lane merge: each lane of the result comes from new_word
// when its strobe is set, otherwise from old_word. Shared with the cache fill path.
//   old_word : word currently held in memory
//   new_word : incoming store data, lanes aligned to the word
//   strb     : one enable per byte lane
//   merged   : resulting word
module spram_byte_merge
    import spram_initiator_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0]   old_word,
    input  logic [W-1:0]   new_word,
    input  logic [W/8-1:0] strb,
    output logic [W-1:0]   merged
);

    // NOTE: the default assignment comes first so every path assigns merged and no latch is inferred.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < W / 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/spram_initiator.sv
// Bus-side initiator for the single-port SPRAM wrapper. Takes one load/store at
// a time and drives the SPRAM pins; sub-word stores run as read-modify-write
// because the SPRAM write mask is fixed at all-ones.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_we/addr/wstrb/wdata : request fields, latched at acceptance
//   rsp_valid/rsp_rdata   : one-cycle completion pulse, load data
//   mem_rd_en/mem_wr_en   : one-cycle SPRAM access pulses
//   mem_addr/mem_wr_data  : SPRAM address (word aligned) and write data
//   mem_rd_data/mem_rd_valid : SPRAM read return
module spram_initiator
    import spram_initiator_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int W  = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [W/8-1:0]    req_wstrb,
    input  logic [W-1:0]      req_wdata,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [AW-1:0]     mem_addr,
    output logic [W-1:0]      mem_wr_data,
    input  logic [W-1:0]      mem_rd_data,
    input  logic              mem_rd_valid
);

    localparam int NB = W / 8;

    state_t          state, state_d;
    logic            accept;
    logic            we_q;
    logic [NB-1:0]   strb_q;
    logic [W-1:0]    wdata_q;
    logic [W-1:0]    merged;
    logic            unused_addr_bits;

    // Byte offset within the word has no meaning to a word-wide SPRAM.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

    spram_byte_merge #(.W(W)) u_merge (
        .old_word (mem_rd_data),
        .new_word (wdata_q),
        .strb     (strb_q),
        .merged   (merged)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_we)           state_d = ST_RD;
                    else if (&req_wstrb)   state_d = ST_WR;
                    else if (|req_wstrb)   state_d = ST_RD;   // partial: fetch old word first
                    else                   state_d = ST_RESP; // empty store: nothing to touch
                end
            end
            ST_RD:       state_d = we_q ? ST_RMW_WAIT : ST_RD_WAIT;
            ST_RD_WAIT:  if (mem_rd_valid) state_d = ST_RESP;
            ST_RMW_WAIT: if (mem_rd_valid) state_d = ST_WR;
            ST_WR:       state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            we_q        <= 1'b0;
            strb_q      <= '0;
            wdata_q     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state <= state_d;

            // Pulses are decoded from the next state so they appear in the
            // very cycle the FSM sits in the issuing state, from a flop.
            mem_rd_en <= (state_d == ST_RD);
            mem_wr_en <= (state_d == ST_WR);
            rsp_valid <= (state_d == ST_RESP);

            if (accept) begin
                we_q     <= req_we;
                strb_q   <= req_wstrb;
                wdata_q  <= req_wdata;
                mem_addr <= {req_addr[AW-1:2], 2'b00};
                if (req_we && (&req_wstrb)) begin
                    mem_wr_data <= req_wdata;
                end
            end

            if (state == ST_RMW_WAIT && mem_rd_valid) begin
                mem_wr_data <= merged;
            end

            if (state == ST_RD_WAIT && mem_rd_valid) begin
                rsp_rdata <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_spram_initiator.sv
module tb_spram_initiator;
    import spram_initiator_pkg::*;

    localparam int AW = 15;
    localparam int W  = 32;
    localparam int NW = 16;   // words exercised (byte addresses 0x00..0x3F)

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_wstrb = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data = '0;
    logic          mem_rd_valid = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    spram_initiator #(.AW(AW), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wstrb    (req_wstrb),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    // ---------------- SPRAM environment model ----------------
    logic [W-1:0] spram [0:NW-1];
    int           extra_delay = 0;
    logic         stray = 1'b0;
    logic         pl_valid = 1'b0;
    logic [3:0]   pl_idx = '0;
    logic [W-1:0] pl_data = '0;
    logic         rd_pend = 1'b0;
    int           rd_left = 0;
    logic [3:0]   rd_idx = '0;

    always @(posedge clk) begin
        mem_rd_valid <= 1'b0;
        mem_rd_data  <= $urandom;   // junk whenever rd_valid is low
        if (pl_valid)  spram[pl_idx] = pl_data;
        if (mem_wr_en) spram[mem_addr[5:2]] = mem_wr_data;
        if (stray) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= 32'hBAD0_BAD0;
        end
        if (mem_rd_en) begin
            if (extra_delay == 0) begin
                mem_rd_valid <= 1'b1;
                mem_rd_data  <= spram[mem_addr[5:2]];
            end else begin
                rd_pend <= 1'b1;
                rd_left <= extra_delay;
                rd_idx  <= mem_addr[5:2];
            end
        end else if (rd_pend) begin
            if (rd_left == 1) begin
                rd_pend      <= 1'b0;
                mem_rd_valid <= 1'b1;
                mem_rd_data  <= spram[rd_idx];
            end
            rd_left <= rd_left - 1;
        end
    end

    // ---------------- monitor (monotonic counters) ----------------
    int           rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp_cnt = 0;
    logic [W-1:0] rsp_log [0:511];

    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (rsp_valid) begin
            rsp_log[rsp_cnt] = rsp_rdata;
            rsp_cnt++;
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] ref_mem [0:NW-1];

    function automatic logic [W-1:0] ref_store(input logic [W-1:0] old_w,
                                               input logic [W-1:0] new_w,
                                               input logic [3:0] strb);
        logic [W-1:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic preload_word(input int idx, input logic [W-1:0] val);
        pl_valid = 1'b1;
        pl_idx   = idx[3:0];
        pl_data  = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_valid = 1'b0;
    endtask

    // One request end to end; starts and ends on a negedge with the DUT idle.
    task automatic do_op(input logic we, input logic [AW-1:0] addr, input logic [3:0] strb,
                         input logic [W-1:0] wd, input int delay, input string tag);
        int exp_lat, exp_rd, exp_wr, k, rd0, wr0, idx;
        logic [AW-1:0] exp_addr;
        logic [W-1:0]  exp_data;
        idx      = int'(addr[5:2]);
        exp_addr = addr & ~15'h3;
        exp_data = ref_mem[idx];
        if (!we)               begin exp_lat = 3 + delay; exp_rd = 1; exp_wr = 0; end
        else if (strb == 4'hF) begin exp_lat = 2;         exp_rd = 0; exp_wr = 1; end
        else if (strb == 4'h0) begin exp_lat = 1;         exp_rd = 0; exp_wr = 0; end
        else                   begin exp_lat = 4 + delay; exp_rd = 1; exp_wr = 1; end

        extra_delay = delay;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = wd;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s idle_ready: got %b want 1", tag, req_ready);
        end
        @(posedge clk);                      // accept edge T
        @(negedge clk);                      // cycle T+1
        req_valid = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_wstrb = $urandom; req_wdata = $urandom;

        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL %s busy_ready: got %b want 0", tag, req_ready);
        end
        compared++;
        if (exp_rd == 1) begin
            if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr) begin
                mismatched++;
                $display("FAIL %s rd_issue: rd_en=%b addr=%h want rd_en=1 addr=%h", tag, mem_rd_en, mem_addr, exp_addr);
            end
        end else if (exp_wr == 1) begin
            if (mem_wr_en !== 1'b1 || mem_addr !== exp_addr || mem_wr_data !== wd) begin
                mismatched++;
                $display("FAIL %s wr_issue: wr_en=%b addr=%h data=%h want 1 %h %h", tag, mem_wr_en, mem_addr, mem_wr_data, exp_addr, wd);
            end
        end else begin
            if (rsp_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL %s empty_rsp: rsp_valid=%b want 1", tag, rsp_valid);
            end
        end

        k = 1;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        #1;
        compared++;
        if (k != exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", tag, k, exp_lat);
        end
        compared++;
        if (rd_cnt - rd0 != exp_rd || wr_cnt - wr0 != exp_wr) begin
            mismatched++;
            $display("FAIL %s pulses: rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rd_cnt - rd0, wr_cnt - wr0, exp_rd, exp_wr);
        end
        if (!we) begin
            compared++;
            if (rsp_rdata !== exp_data) begin
                mismatched++;
                $display("FAIL %s rdata: got %h want %h", tag, rsp_rdata, exp_data);
            end
        end else begin
            ref_mem[idx] = ref_store(ref_mem[idx], wd, strb);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s after_rsp: rsp_valid=%b req_ready=%b want 0 1", tag, rsp_valid, req_ready);
        end
        extra_delay = 0;
    endtask

    task automatic check_reset_values(input string tag);
        compared++;
        if ({req_ready, rsp_valid, mem_rd_en, mem_wr_en} !== 4'b1000 ||
            rsp_rdata !== '0 || mem_addr !== '0 || mem_wr_data !== '0) begin
            mismatched++;
            $display("FAIL %s reset_vals: ready=%b rsp=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want 1 0 0 0 0 0 0",
                     tag, req_ready, rsp_valid, mem_rd_en, mem_wr_en, rsp_rdata, mem_addr, mem_wr_data);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int r0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("por_release");
        for (int i = 0; i < NW; i++) preload_word(i, $urandom);
    endtask

    task automatic test_load;
        preload_word(1, 32'hDEAD_BEEF);
        do_op(1'b0, 15'h0004, 4'h0, '0, 0, "load");
    endtask

    task automatic test_reset_mid_load;
        int r0;
        extra_delay = 3;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h000C; req_wstrb = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);                     // DUT is waiting for rd_valid
        r0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_load");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);          // late rd_valid from the dropped read lands here
        compared++;
        if (rsp_cnt != r0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_load_drop: rsp pulses=%0d ready=%b want 0 1", rsp_cnt - r0, req_ready);
        end
        extra_delay = 0;
    endtask

    task automatic test_full_store;
        do_op(1'b1, 15'h0010, 4'hF, 32'h1234_5678, 0, "full_store");
        do_op(1'b0, 15'h0010, 4'h0, '0, 0, "full_store_rb");
    endtask

    task automatic test_partial_store;
        preload_word(8, 32'hAABB_CCDD);
        do_op(1'b1, 15'h0022, 4'b0010, 32'h0000_5500, 0, "partial");
        do_op(1'b0, 15'h0020, 4'h0, '0, 0, "partial_rb");
        compared++;
        if (rsp_rdata !== 32'hAABB_55DD) begin
            mismatched++;
            $display("FAIL partial_word: got %h want aabb55dd", rsp_rdata);
        end
    endtask

    task automatic test_zero_strb;
        do_op(1'b1, 15'h0030, 4'h0, 32'hFFFF_FFFF, 0, "zero_strb");
        do_op(1'b0, 15'h0030, 4'h0, '0, 0, "zero_strb_rb");
    endtask

    task automatic test_back_to_back;
        int r0, rd0, wr0, b0, n;
        logic [W-1:0] old_w, new_w;
        old_w = ref_mem[2];
        new_w = 32'hC0FF_EE01;
        r0 = rsp_cnt; rd0 = rd_cnt; wr0 = wr_cnt; b0 = both_cnt;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_we    = (i == 1);
            req_addr  = 15'h0008;
            req_wstrb = (i == 1) ? 4'hF : 4'h0;
            req_wdata = new_w;
            n = 0;
            while (req_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            compared++;
            if (n >= 20) begin
                mismatched++;
                $display("FAIL b2b_accept%0d: timeout req_ready=%b want 1", i, req_ready);
            end
            @(posedge clk);
            @(negedge clk);
            compared++;
            if (req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_busy%0d: req_ready=%b want 0", i, req_ready);
            end
        end
        req_valid = 1'b0;
        ref_mem[2] = new_w;
        n = 0;
        while (rsp_cnt < r0 + 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        compared++;
        if (rsp_cnt - r0 != 3) begin
            mismatched++;
            $display("FAIL b2b_rsp_count: got %0d want 3", rsp_cnt - r0);
        end
        compared++;
        if (rsp_log[r0] !== old_w || rsp_log[r0 + 2] !== new_w) begin
            mismatched++;
            $display("FAIL b2b_order: got %h %h want %h %h", rsp_log[r0], rsp_log[r0 + 2], old_w, new_w);
        end
        compared++;
        if (rd_cnt - rd0 != 2 || wr_cnt - wr0 != 1 || both_cnt != b0) begin
            mismatched++;
            $display("FAIL b2b_pulses: rd=%0d wr=%0d overlap=%0d want 2 1 0", rd_cnt - rd0, wr_cnt - wr0, both_cnt - b0);
        end
    endtask

    task automatic test_rd_valid_delay;
        int r0;
        do_op(1'b0, 15'h0014, 4'h0, '0, 3, "slow_load");
        do_op(1'b1, 15'h0018, 4'b1001, $urandom, 3, "slow_rmw");
        do_op(1'b0, 15'h0018, 4'h0, '0, 0, "slow_rmw_rb");
        r0 = rsp_cnt;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL stray_rd_valid: rsp_valid=%b ready=%b want 0 1", rsp_valid, req_ready);
            end
        end
        compared++;
        if (rsp_cnt != r0) begin
            mismatched++;
            $display("FAIL stray_rsp_count: got %0d want 0", rsp_cnt - r0);
        end
        do_op(1'b0, 15'h0018, 4'h0, '0, 0, "after_stray");
    endtask

    task automatic test_random;
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    strb;
        int            sel;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 63));
            sel  = $urandom_range(0, 3);
            strb = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            do_op(we, addr, strb, $urandom, $urandom_range(0, 2), "random");
        end
        for (int i = 0; i < NW; i++) begin
            do_op(1'b0, AW'(i * 4), 4'h0, '0, 0, "sweep");
        end
        compared++;
        if (both_cnt != 0) begin
            mismatched++;
            $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reset_mid_load();
        test_full_store();
        test_partial_store();
        test_zero_strb();
        test_back_to_back();
        test_rd_valid_delay();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
